axis_checksum_append: RTL and testbench

- AXI4-Stream stage placed directly downstream of the stream FIFO's master port.
- Passes each packet through unchanged, then appends one trailer word holding the two's-complement negation of the 32-bit word sum, so the sum of all output words in the packet (trailer included) is 0 mod 2^32.
- Enforces a maximum packet length and exposes a packet counter and a sticky oversize flag for the register space to read.

---
 rtl/axis_checksum_append.sv | 117 +++++++++++
 tb/tb_axis_checksum_append.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_checksum_append.sv
// AXI4-Stream pass-through that appends a negated 32-bit word-sum trailer per packet.
// Enforces a maximum packet length and keeps a packet counter plus a sticky oversize flag.
module axis_checksum_append #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  clear,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  err_oversize
);

    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        TRAILER
    } state_t;

    state_t                r_state;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [LW-1:0]         r_len;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last;
    logic [CNT_WIDTH-1:0]  r_pkt_count;
    logic                  r_err;

    logic                  w_out_free;
    logic                  w_acc;
    logic                  w_first;
    logic [LW-1:0]         w_len_next;
    logic                  w_hit_max;
    logic                  w_last;
    logic                  w_mode;
    logic [DATA_WIDTH-1:0] w_sum_next;

    always_comb begin
        w_out_free    = !r_m_valid || m_axis_tready;
        s_axis_tready = resetn && (r_state != TRAILER) && w_out_free;
        w_acc         = s_axis_tvalid && s_axis_tready;
        w_first       = (r_state == IDLE);
        w_len_next    = w_first ? LW'(1) : r_len + LW'(1);
        w_hit_max     = (w_len_next == LW'(MAX_LEN));
        w_last        = s_axis_tlast || w_hit_max;
        w_mode        = w_first ? enable : r_mode;
        w_sum_next    = w_first ? s_axis_tdata : r_sum + s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_sum       <= '0;
            r_len       <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
            r_pkt_count <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_acc) begin
                r_mode    <= w_mode;
                r_sum     <= w_sum_next;
                r_m_valid <= 1'b1;
                r_m_data  <= s_axis_tdata;
                // with a trailer pending, only the trailer carries tlast
                r_m_last  <= !w_mode && w_last;
                if (w_last) begin
                    r_state <= w_mode ? TRAILER : IDLE;
                    r_len   <= '0;
                end else begin
                    r_state <= PASS;
                    r_len   <= w_len_next;
                end
            end else if (r_state == TRAILER && w_out_free) begin
                r_m_valid <= 1'b1;
                r_m_data  <= ~r_sum + DATA_WIDTH'(1);
                r_m_last  <= 1'b1;
                r_sum     <= '0;
                r_state   <= IDLE;
            end else if (m_axis_tready) begin
                r_m_valid <= 1'b0;
            end

            if (clear) begin
                r_pkt_count <= '0;
                r_err       <= 1'b0;
            end else begin
                if (r_m_valid && m_axis_tready && r_m_last)
                    r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
                if (w_acc && w_hit_max && !s_axis_tlast)
                    r_err <= 1'b1;
            end
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tlast  = r_m_last;
    assign pkt_count     = r_pkt_count;
    assign err_oversize  = r_err;

endmodule

// File: tb/tb_axis_checksum_append.sv
// Directed bench for axis_checksum_append with MAX_LEN=4.
// Output beats are collected at the falling edge and compared against hand-built expectations.
module tb_axis_checksum_append;

    localparam int DW = 32;
    localparam int ML = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic [CW-1:0] pkt_count;
    logic          err_oversize;

    int            n_assert = 0;
    int            n_fail = 0;
    logic [32:0]   exp_q[$];
    logic [32:0]   got_q[$];
    logic [31:0]   pkt[16];
    bit            rnd_ready = 1'b0;
    bit            p_stall = 1'b0;
    logic [32:0]   p_beat = '0;

    axis_checksum_append #(
        .DATA_WIDTH(DW),
        .MAX_LEN   (ML),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .clear        (clear),
        .s_axis_tready(s_tready),
        .s_axis_tdata (s_tdata),
        .s_axis_tlast (s_tlast),
        .s_axis_tvalid(s_tvalid),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tdata (m_tdata),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .pkt_count    (pkt_count),
        .err_oversize (err_oversize)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (p_stall)
                chk("stall_hold", {30'd0, m_tvalid, m_tlast, m_tdata},
                    {30'd0, 1'b1, p_beat});
            if (m_tvalid && m_tready)
                got_q.push_back({m_tlast, m_tdata});
            p_stall = m_tvalid && !m_tready;
            p_beat  = {m_tlast, m_tdata};
        end else begin
            p_stall = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            m_tready = 1'($urandom_range(0, 1));
        end
    end

    function automatic void ex(input logic last, input logic [31:0] d);
        exp_q.push_back({last, d});
    endfunction

    task automatic wait_acc();
        bit done = 1'b0;
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            if (s_tready) done = 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input int n, input logic en, input logic lst);
        for (int i = 0; i < n; i++) begin
            s_tdata  = pkt[i];
            s_tlast  = lst && (i == n - 1);
            s_tvalid = 1'b1;
            enable   = en;
            wait_acc();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain(input bit sum_chk);
        int t = 0;
        logic [31:0] sum = '0;
        while (got_q.size() < exp_q.size() && t < 1000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk("beat", {31'd0, got_q[i]}, {31'd0, exp_q[i]});
            if (sum_chk) begin
                sum = sum + got_q[i][31:0];
                if (got_q[i][32]) begin
                    chk("pkt_sum", {32'd0, sum}, 64'd0);
                    sum = '0;
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        int len;
        logic [31:0] sum;
        bit last;
        bit seen;

        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_data", {32'd0, m_tdata}, 64'd0);
        chk("rst_last", {63'd0, m_tlast}, 64'd0);
        chk("rst_tready", {63'd0, s_tready}, 64'd0);
        chk("rst_cnt", {48'd0, pkt_count}, 64'd0);
        chk("rst_err", {63'd0, err_oversize}, 64'd0);
        resetn = 1'b1;

        pkt[0] = 32'h1; pkt[1] = 32'h2; pkt[2] = 32'h3;
        ex(0, 32'h1); ex(0, 32'h2); ex(0, 32'h3); ex(1, 32'hFFFFFFFA);
        send(3, 1'b1, 1'b1);
        drain(0);
        chk("t1_cnt", {48'd0, pkt_count}, 64'd1);
        chk("t1_err", {63'd0, err_oversize}, 64'd0);

        pkt[0] = 32'h80000000;
        ex(0, 32'h80000000); ex(1, 32'h80000000);
        send(1, 1'b1, 1'b1);
        pkt[0] = 32'hFFFFFFFF; pkt[1] = 32'h1;
        ex(0, 32'hFFFFFFFF); ex(0, 32'h1); ex(1, 32'h0);
        send(2, 1'b1, 1'b1);
        drain(0);
        chk("t2_cnt", {48'd0, pkt_count}, 64'd3);

        pkt[0] = 32'hA5A5A5A5; pkt[1] = 32'h5A5A5A5A;
        ex(0, 32'hA5A5A5A5); ex(1, 32'h5A5A5A5A);
        send(2, 1'b0, 1'b1);
        drain(0);
        chk("t3_cnt", {48'd0, pkt_count}, 64'd4);

        for (int i = 0; i < 6; i++) pkt[i] = 32'(i + 1);
        ex(0, 32'h1); ex(0, 32'h2); ex(0, 32'h3); ex(0, 32'h4);
        ex(1, 32'hFFFFFFF6);
        ex(0, 32'h5); ex(0, 32'h6); ex(1, 32'hFFFFFFF5);
        send(6, 1'b1, 1'b1);
        drain(0);
        chk("t4_err", {63'd0, err_oversize}, 64'd1);
        chk("t4_cnt", {48'd0, pkt_count}, 64'd6);

        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_cnt", {48'd0, pkt_count}, 64'd0);
        chk("clr_err", {63'd0, err_oversize}, 64'd0);

        for (int i = 0; i < 4; i++) pkt[i] = 32'h1;
        ex(0, 32'h1); ex(0, 32'h1); ex(0, 32'h1); ex(0, 32'h1);
        ex(1, 32'hFFFFFFFC);
        send(4, 1'b1, 1'b1);
        drain(0);
        chk("exact_max_err", {63'd0, err_oversize}, 64'd0);
        chk("exact_max_cnt", {48'd0, pkt_count}, 64'd1);

        rnd_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            n = $urandom_range(1, 10);
            len = 0;
            sum = '0;
            for (int i = 0; i < n; i++) begin
                pkt[i] = $urandom;
                sum = sum + pkt[i];
                len++;
                last = (i == n - 1) || (len == ML);
                ex(0, pkt[i]);
                if (last) begin
                    ex(1, ~sum + 32'd1);
                    len = 0;
                    sum = '0;
                end
            end
            send(n, 1'b1, 1'b1);
        end
        drain(1);
        rnd_ready = 1'b0;
        @(posedge clk); #2;
        m_tready = 1'b1;

        pkt[0] = 32'h10; pkt[1] = 32'h20;
        ex(0, 32'h10);
        send(2, 1'b1, 1'b0);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", {63'd0, m_tvalid}, 64'd0);
        chk("mid_rst_data", {32'd0, m_tdata}, 64'd0);
        chk("mid_rst_last", {63'd0, m_tlast}, 64'd0);
        chk("mid_rst_tready", {63'd0, s_tready}, 64'd0);
        chk("mid_rst_cnt", {48'd0, pkt_count}, 64'd0);
        resetn = 1'b1;
        pkt[0] = 32'h7;
        ex(0, 32'h7); ex(1, 32'hFFFFFFF9);
        send(1, 1'b1, 1'b1);
        drain(0);
        chk("t6_cnt", {48'd0, pkt_count}, 64'd1);

        pkt[0] = 32'h5;
        ex(0, 32'h5); ex(1, 32'hFFFFFFFB);
        send(1, 1'b1, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (m_tvalid && m_tlast) begin
                seen = 1'b1;
                clear = 1'b1;
                @(posedge clk); #1;
                clear = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("clr_trailer_seen", {63'd0, seen}, 64'd1);
        chk("clr_trailer_cnt", {48'd0, pkt_count}, 64'd0);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
